// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter; presc exists only when
// CNT_PRESCALE_EN is defined.
interface updown_mod_counter_if #(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
);
   logic             clr;
   logic             clr_flags;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             pause;
   logic             dir;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] count;
   logic             zero;
   logic             tc;
   logic             ovf;
   logic             unf;
`ifdef CNT_PRESCALE_EN
   logic [PRESC_W-1:0] presc;
`endif

   if (WIDTH < 2 || PRESC_W < 1) begin : g_param_check
      $error("updown_mod_counter_if: bad WIDTH/PRESC_W");
   end

   modport master (
`ifdef CNT_PRESCALE_EN
      output presc,
`endif
      output clr, clr_flags, load, load_val, pause, dir, limit,
      input  count, zero, tc, ovf, unf
   );

   modport slave (
`ifdef CNT_PRESCALE_EN
      input  presc,
`endif
      input  clr, clr_flags, load, load_val, pause, dir, limit,
      output count, zero, tc, ovf, unf
   );
endinterface

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with wrap/saturate, terminal-count pulse
// and sticky ovf/unf flags. Optional step prescaler: define CNT_PRESCALE_EN.
module updown_mod_counter #(
   parameter int WIDTH    = 8,
   parameter int SATURATE = 0,
   parameter int PRESC_W  = 4
) (
   input logic                 clk,
   input logic                 reset,
   updown_mod_counter_if.slave bus
);
   logic [WIDTH-1:0] count_r;
   logic [WIDTH-1:0] count_nxt_s;
   logic             tc_r;
   logic             tc_nxt_s;
   logic             ovf_r;
   logic             unf_r;
   logic             ovf_set_s;
   logic             unf_set_s;
   logic             tick_s;

   if (WIDTH < 2 || PRESC_W < 1) begin : g_param_check
      $error("updown_mod_counter: bad WIDTH/PRESC_W");
   end

`ifdef CNT_PRESCALE_EN
   logic [PRESC_W-1:0] presc_r;
   logic [PRESC_W-1:0] presc_nxt_s;

   // Prescaler phase: frozen by pause, zeroed by clr/load, tick at presc.
   always_comb begin
      presc_nxt_s = presc_r;
      tick_s      = 1'b0;
      if (bus.clr || bus.load) begin
         presc_nxt_s = {PRESC_W{1'b0}};
      end else if (bus.pause) begin
         presc_nxt_s = presc_r;
      end else if (presc_r == bus.presc) begin
         presc_nxt_s = {PRESC_W{1'b0}};
         tick_s      = 1'b1;
      end else begin
         presc_nxt_s = presc_r + PRESC_W'(1);
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_r <= {PRESC_W{1'b0}};
      end else begin
         presc_r <= presc_nxt_s;
      end
   end
`else
   assign tick_s = 1'b1;
`endif

   // Next count and boundary events; priority clr > load > pause > step.
   always_comb begin
      count_nxt_s = count_r;
      tc_nxt_s    = 1'b0;
      ovf_set_s   = 1'b0;
      unf_set_s   = 1'b0;
      if (bus.clr) begin
         count_nxt_s = {WIDTH{1'b0}};
      end else if (bus.load) begin
         count_nxt_s = bus.load_val;
      end else if (bus.pause || !tick_s) begin
         count_nxt_s = count_r;
      end else begin
         case (bus.dir)
            1'b0: begin
               // count above limit also counts as the upper boundary
               if (count_r < bus.limit) begin
                  count_nxt_s = count_r + WIDTH'(1);
               end else begin
                  count_nxt_s = (SATURATE != 0) ? count_r : {WIDTH{1'b0}};
                  tc_nxt_s    = 1'b1;
                  ovf_set_s   = 1'b1;
               end
            end
            1'b1: begin
               if (count_r != {WIDTH{1'b0}}) begin
                  count_nxt_s = count_r - WIDTH'(1);
               end else begin
                  count_nxt_s = (SATURATE != 0) ? {WIDTH{1'b0}} : bus.limit;
                  tc_nxt_s    = 1'b1;
                  unf_set_s   = 1'b1;
               end
            end
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // Count, terminal-count pulse and sticky flags (set beats clr_flags).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= {WIDTH{1'b0}};
         tc_r    <= 1'b0;
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         tc_r    <= tc_nxt_s;
         ovf_r   <= ovf_set_s | (ovf_r & ~bus.clr_flags);
         unf_r   <= unf_set_s | (unf_r & ~bus.clr_flags);
      end
   end

   assign bus.count = count_r;
   assign bus.zero  = (count_r == {WIDTH{1'b0}});
   assign bus.tc    = tc_r;
   assign bus.ovf   = ovf_r;
   assign bus.unf   = unf_r;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: a wrap and a saturate instance share stimulus
// and are compared every cycle against an integer model.
module tb_updown_mod_counter;
   localparam int W  = 8;
   localparam int PW = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic clr = 1'b0, clr_flags = 1'b0, load = 1'b0, pause = 1'b0, dir = 1'b0;
   logic [W-1:0] load_val = 8'd0, limit = 8'd9;
   logic [PW-1:0] presc = 4'd0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   updown_mod_counter_if #(.WIDTH(W), .PRESC_W(PW)) if_w ();
   updown_mod_counter_if #(.WIDTH(W), .PRESC_W(PW)) if_s ();

   assign if_w.clr = clr;       assign if_s.clr = clr;
   assign if_w.clr_flags = clr_flags; assign if_s.clr_flags = clr_flags;
   assign if_w.load = load;     assign if_s.load = load;
   assign if_w.load_val = load_val; assign if_s.load_val = load_val;
   assign if_w.pause = pause;   assign if_s.pause = pause;
   assign if_w.dir = dir;       assign if_s.dir = dir;
   assign if_w.limit = limit;   assign if_s.limit = limit;
`ifdef CNT_PRESCALE_EN
   assign if_w.presc = presc;   assign if_s.presc = presc;
`endif

   updown_mod_counter #(.WIDTH(W), .SATURATE(0), .PRESC_W(PW)) u_wrap (
      .clk(clk), .reset(reset), .bus(if_w.slave));
   updown_mod_counter #(.WIDTH(W), .SATURATE(1), .PRESC_W(PW)) u_sat (
      .clk(clk), .reset(reset), .bus(if_s.slave));

   typedef struct {
      int cnt;
      bit tc;
      bit ovf;
      bit unf;
      int pre;
   } mstate_t;

   mstate_t m [2];

   function automatic mstate_t next_state(mstate_t s, bit sat);
      mstate_t n = s;
      bit step;
      int lim = int'(limit);
      n.tc = 1'b0;
      step = 1'b0;
      if (clr) begin
         n.cnt = 0; n.pre = 0;
      end else if (load) begin
         n.cnt = int'(load_val); n.pre = 0;
      end else if (!pause) begin
`ifdef CNT_PRESCALE_EN
         if (s.pre == int'(presc)) begin step = 1'b1; n.pre = 0; end
         else n.pre = s.pre + 1;
`else
         step = 1'b1;
`endif
      end
      if (step && !dir) begin
         if (s.cnt < lim) n.cnt = s.cnt + 1;
         else begin n.tc = 1'b1; n.ovf = 1'b1; n.cnt = sat ? s.cnt : 0; end
      end else if (step && dir) begin
         if (s.cnt > 0) n.cnt = s.cnt - 1;
         else begin n.tc = 1'b1; n.unf = 1'b1; n.cnt = sat ? 0 : lim; end
      end
      if (clr_flags && !(n.ovf && !s.ovf)) n.ovf = (step && !dir && n.tc);
      if (clr_flags && !(n.unf && !s.unf)) n.unf = (step && dir && n.tc);
      return n;
   endfunction

   // Reference model state, advanced on every clock edge, cleared by reset.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m[0] <= '{0, 1'b0, 1'b0, 1'b0, 0};
         m[1] <= '{0, 1'b0, 1'b0, 1'b0, 0};
      end else begin
         m[0] <= next_state(m[0], 1'b0);
         m[1] <= next_state(m[1], 1'b1);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare both instances against the model mid-cycle.
   always @(negedge clk) begin
      chk("wrap.count", int'(if_w.count), m[0].cnt);
      chk("wrap.zero",  int'(if_w.zero),  int'(m[0].cnt == 0));
      chk("wrap.tc",    int'(if_w.tc),    int'(m[0].tc));
      chk("wrap.ovf",   int'(if_w.ovf),   int'(m[0].ovf));
      chk("wrap.unf",   int'(if_w.unf),   int'(m[0].unf));
      chk("sat.count",  int'(if_s.count), m[1].cnt);
      chk("sat.zero",   int'(if_s.zero),  int'(m[1].cnt == 0));
      chk("sat.tc",     int'(if_s.tc),    int'(m[1].tc));
      chk("sat.ovf",    int'(if_s.ovf),   int'(m[1].ovf));
      chk("sat.unf",    int'(if_s.unf),   int'(m[1].unf));
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      cyc(2);
      chk("rst.count", int'(if_w.count), 0);
      chk("rst.flags", int'({if_w.tc, if_w.ovf, if_w.unf}), 0);
      reset = 1'b1;

      // wrap up, limit 9, 12 steps from 0
      limit = 8'd9; dir = 1'b0; clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         chk("up.count", int'(if_w.count), (i + 1) % 10);
         chk("up.tc", int'(if_w.tc), int'(i == 9));
      end
      chk("up.ovf", int'(if_w.ovf), 1);

      // wrap down from 0 -> 9, then clr_flags
      clr = 1'b1; cyc(1);
      clr = 1'b0; dir = 1'b1; cyc(1);
      chk("dn.count", int'(if_w.count), 9);
      chk("dn.tc", int'(if_w.tc), 1);
      chk("dn.unf", int'(if_w.unf), 1);
      cyc(1);
      chk("dn.count2", int'(if_w.count), 8);
      clr_flags = 1'b1; cyc(1);
      clr_flags = 1'b0;
      chk("dn.unf_clr", int'(if_w.unf), 0);

      // saturate up from 4 with limit 5, then down from 1
      limit = 8'd5; dir = 1'b0; load = 1'b1; load_val = 8'd4; cyc(1);
      load = 1'b0;
      chk("sat.load", int'(if_s.count), 4);
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("sat.up", int'(if_s.count), 5);
         chk("sat.up_tc", int'(if_s.tc), int'(i > 0));
      end
      load = 1'b1; load_val = 8'd1; dir = 1'b1; cyc(1);
      load = 1'b0;
      cyc(1);
      chk("sat.dn", int'(if_s.count), 0);
      chk("sat.dn_tc", int'(if_s.tc), 0);
      cyc(1);
      chk("sat.dn2", int'(if_s.count), 0);
      chk("sat.dn2_tc", int'(if_s.tc), 1);
      chk("sat.unf", int'(if_s.unf), 1);

      // load above limit while paused, then an up step wraps to 0
      load = 1'b1; load_val = 8'd200; limit = 8'd100; pause = 1'b1; dir = 1'b0;
      cyc(1);
      load = 1'b0;
      chk("big.load", int'(if_w.count), 200);
      cyc(1);
      chk("big.paused", int'(if_w.count), 200);
      pause = 1'b0; cyc(1);
      chk("big.wrap", int'(if_w.count), 0);
      chk("big.tc", int'(if_w.tc), 1);
      chk("big.sat", int'(if_s.count), 200);
      clr = 1'b1; load = 1'b1; cyc(1);
      clr = 1'b0; load = 1'b0;
      chk("clr_load", int'(if_w.count), 0);

`ifdef CNT_PRESCALE_EN
      presc = 4'd3; clr = 1'b1; cyc(1);
      clr = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cyc(1);
         chk("presc.count", int'(if_w.count), i / 4);
      end
      pause = 1'b1; cyc(2);
      pause = 1'b0;
      cyc(3);
      chk("presc.phase", int'(if_w.count), 2);
      cyc(1);
      chk("presc.step", int'(if_w.count), 3);
      presc = 4'd0;
`endif

      // async reset mid-count at 0x37
      load = 1'b1; load_val = 8'h37; cyc(1);
      load = 1'b0; pause = 1'b1; clr_flags = 1'b0;
      @(posedge clk); #2;
      reset = 1'b0; #1;
      chk("arst.count", int'(if_w.count), 0);
      chk("arst.flags", int'({if_w.tc, if_w.ovf, if_w.unf}), 0);
      cyc(1);
      reset = 1'b1; pause = 1'b0;

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         clr       = ($urandom_range(0, 31) == 0);
         clr_flags = ($urandom_range(0, 15) == 0);
         load      = ($urandom_range(0, 15) == 0);
         load_val  = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255))
                                                  : W'($urandom_range(0, 15));
         pause     = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 9) == 0) dir = ~dir;
         if ($urandom_range(0, 49) == 0)
            limit = ($urandom_range(0, 9) == 0) ? 8'd255 : W'($urandom_range(0, 12));
`ifdef CNT_PRESCALE_EN
         if ($urandom_range(0, 49) == 0) presc = PW'($urandom_range(0, 3));
`endif
         if ($urandom_range(0, 199) == 0) reset = 1'b0;
         else reset = 1'b1;
         cyc(1);
      end
      reset = 1'b1;
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
